// File: rtl/alu_issue_ctrl_if.sv
// Handshake, register-file and ALU signal bundle between the issue controller
// and its surroundings (fetch, register file, ALU).
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_carry_in;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;

    // Environment side: fetch, register file and ALU.
    modport master (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_c, alu_flags,
        input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_carry_in, alu_opcode, psr, done, illegal
    );

    // Controller side.
    modport slave (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_c, alu_flags,
        output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_carry_in, alu_opcode, psr, done, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-cycle decode/issue controller: fetch handshake, operand read, ALU execute,
// then register/PSR writeback.
module alu_issue_ctrl #(
    parameter logic [4:0] PSR_RESET = 5'b00000
) (
    input logic            clk,
    input logic            reset,
    alu_issue_ctrl_if.slave io_bus
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_ir;
    logic [3:0]  r_raddr_a;
    logic [3:0]  r_raddr_b;
    logic [15:0] r_result;
    logic [4:0]  r_flags;
    logic [4:0]  r_psr;

    logic [3:0]  w_hi;
    logic [3:0]  w_rd;
    logic [3:0]  w_ext;
    logic [3:0]  w_rs;
    logic        w_nop;
    logic        w_legal;
    logic        w_cmp;
    logic        w_write;
    logic        w_upd;
    logic [7:0]  w_opcode;
    logic [15:0] w_b;
    logic        w_accept;

    assign w_hi     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_ext    = r_ir[7:4];
    assign w_rs     = r_ir[3:0];
    assign w_nop    = (r_ir == 16'h0000);
    assign w_write  = w_legal & ~w_nop & ~w_cmp;
    assign w_upd    = w_legal & ~w_nop;
    assign w_accept = (r_state == S_IDLE) & io_bus.instr_valid;

    // Decode of the latched instruction; B comes from the register file or the IR.
    always_comb begin
        w_legal  = 1'b0;
        w_cmp    = 1'b0;
        w_opcode = {w_hi, 4'b0000};
        w_b      = {8'h00, r_ir[7:0]};
        case (w_hi)
            4'h0: begin
                w_opcode = {4'h0, w_ext};
                w_b      = io_bus.rf_rdata_b;
                case (w_ext)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF: w_legal = 1'b1;
                    4'h8, 4'hB, 4'hC: begin
                        w_legal = 1'b1;
                        w_cmp   = 1'b1;
                    end
                    default: w_legal = w_nop;
                endcase
            end
            4'h8: begin
                w_opcode = {4'h8, w_ext};
                w_legal  = ~w_ext[3];
                w_b      = w_ext[2] ? io_bus.rf_rdata_b : {12'h000, w_rs};
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h6: w_legal = 1'b1;
            4'h5, 4'h9, 4'hB: begin
                w_legal = 1'b1;
                w_cmp   = (w_hi == 4'hB);
                w_b     = {{8{r_ir[7]}}, r_ir[7:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir      <= 16'h0000;
            r_raddr_a <= 4'h0;
            r_raddr_b <= 4'h0;
            r_result  <= 16'h0000;
            r_flags   <= 5'b00000;
            r_psr     <= PSR_RESET;
        end else begin
            // Read addresses are captured with the IR so they are stable in S_READ.
            if (w_accept) begin
                r_ir      <= io_bus.instr;
                r_raddr_a <= io_bus.instr[11:8];
                r_raddr_b <= io_bus.instr[3:0];
            end
            if (r_state == S_EXEC) begin
                r_result <= io_bus.alu_c;
                r_flags  <= io_bus.alu_flags;
            end
            if ((r_state == S_WB) && w_upd) begin
                r_psr <= r_flags;
            end
        end
    end

    always_comb begin
        w_state_next        = r_state;
        io_bus.instr_ready  = 1'b0;
        io_bus.alu_a        = 16'h0000;
        io_bus.alu_b        = 16'h0000;
        io_bus.alu_opcode   = 8'h00;
        io_bus.alu_carry_in = 1'b0;
        io_bus.rf_we        = 1'b0;
        io_bus.rf_waddr     = 4'h0;
        io_bus.rf_wdata     = 16'h0000;
        io_bus.done         = 1'b0;
        io_bus.illegal      = 1'b0;
        case (r_state)
            S_IDLE: begin
                io_bus.instr_ready = 1'b1;
                if (io_bus.instr_valid) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: w_state_next = S_EXEC;
            S_EXEC: begin
                io_bus.alu_a        = io_bus.rf_rdata_a;
                io_bus.alu_b        = w_b;
                io_bus.alu_opcode   = w_opcode;
                io_bus.alu_carry_in = r_psr[3];
                w_state_next        = S_WB;
            end
            S_WB: begin
                io_bus.rf_we    = w_write;
                io_bus.rf_waddr = w_rd;
                io_bus.rf_wdata = r_result;
                io_bus.done     = 1'b1;
                io_bus.illegal  = ~w_legal;
                w_state_next    = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign io_bus.rf_raddr_a = r_raddr_a;
    assign io_bus.rf_raddr_b = r_raddr_b;
    assign io_bus.psr        = r_psr;

endmodule
